// File: rtl/hex_dump_pkg.sv
// Shared types, ASCII constants and small helpers for the hex_dump_tx block.
package hex_dump_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // ASCII code points used when building a frame.
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    // Character index width: enough for the six digits plus CR and LF.
    localparam int IDX_W = 3;

    // Index of the final character of a frame (CR LF adds two characters).
    function automatic logic [IDX_W-1:0] frame_last(input logic send_crlf);
        logic [IDX_W-1:0] last_s;
        if (send_crlf) begin
            last_s = 3'd7;
        end else begin
            last_s = 3'd5;
        end
        return last_s;
    endfunction

    // Selects the display digit for a character position, leftmost digit first.
    // Positions beyond the six digits return zero; they are replaced by CR/LF.
    function automatic logic [3:0] pick_nibble(input logic [23:0] value,
                                               input logic [IDX_W-1:0] idx);
        logic [3:0] nib_s;
        case (idx)
            3'd0:    nib_s = value[23:20];
            3'd1:    nib_s = value[19:16];
            3'd2:    nib_s = value[15:12];
            3'd3:    nib_s = value[11:8];
            3'd4:    nib_s = value[7:4];
            3'd5:    nib_s = value[3:0];
            default: nib_s = 4'h0;
        endcase
        return nib_s;
    endfunction

endpackage

// File: rtl/hex_dump_tx_nibble_to_ascii.sv
// Combinational hex-digit to ASCII converter; letter case fixed at elaboration.
module nibble_to_ascii
    import hex_dump_pkg::*;
#(
    parameter int LOWER_CASE = 0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Base letter for digits A-F, chosen once by the parameter.
    localparam logic [7:0] LETTER_BASE = (LOWER_CASE != 0) ? ASCII_LA : ASCII_UA;

    // Map 0-9 onto '0'..'9' and 10-15 onto the selected 'A'..'F' range.
    always_comb begin
        ascii = ASCII_0;
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = LETTER_BASE + ({4'h0, nibble} - 8'd10);
        end
    end

endmodule

// File: rtl/hex_dump_tx.sv
// Snapshots the six-digit display value on a start pulse and streams it to
// uart_tx as ASCII text, most significant digit first, optionally ending in
// CR LF. Each character waits for a free line, strobes tx_en for one cycle,
// then waits for uart_tx to acknowledge (tx_busy high) and finish (tx_busy low).
module hex_dump_tx
    import hex_dump_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 1024,
    parameter int LOWER_CASE   = 0,
    parameter int SEND_CRLF    = 1
) (
    input  logic        clk_60mhz,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] hex_in,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    // Acknowledge counter sized to hold BUSY_TIMEOUT-1; never narrower than 1 bit.
    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [IDX_W-1:0] LAST_IDX = frame_last(SEND_CRLF != 0);

    // State and datapath registers.
    state_t             state_r;
    logic [23:0]        snapshot_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               tx_en_r;
    logic [7:0]         tx_data_r;
    logic               busy_r;
    logic               done_r;
    logic               timeout_err_r;

    // Next-state values.
    state_t             state_s;
    logic [23:0]        snapshot_s;
    logic [IDX_W-1:0]   idx_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               tx_en_s;
    logic [7:0]         tx_data_s;
    logic               busy_s;
    logic               done_s;
    logic               timeout_err_s;

    // Character for the current index.
    logic [3:0]         nibble_s;
    logic [7:0]         digit_ascii_s;
    logic [7:0]         char_s;

    assign nibble_s = pick_nibble(snapshot_r, idx_r);

    nibble_to_ascii #(
        .LOWER_CASE (LOWER_CASE)
    ) u_nibble_to_ascii (
        .nibble (nibble_s),
        .ascii  (digit_ascii_s)
    );

    // Positions 6 and 7 carry the line terminator; all others are digits.
    always_comb begin
        char_s = digit_ascii_s;
        case (idx_r)
            3'd6:    char_s = ASCII_CR;
            3'd7:    char_s = ASCII_LF;
            default: char_s = digit_ascii_s;
        endcase
    end

    // Next-state and output decode; strobes default low so each lasts one cycle.
    always_comb begin
        state_s       = state_r;
        snapshot_s    = snapshot_r;
        idx_s         = idx_r;
        cnt_s         = cnt_r;
        tx_en_s       = 1'b0;
        tx_data_s     = tx_data_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        timeout_err_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    snapshot_s = hex_in;
                    idx_s      = {IDX_W{1'b0}};
                    busy_s     = 1'b1;
                    state_s    = ST_SEND;
                end else begin
                    busy_s     = 1'b0;
                end
            end

            ST_SEND: begin
                // Hold off while the line is still occupied by a previous byte.
                if (!tx_busy) begin
                    tx_data_s = char_s;
                    tx_en_s   = 1'b1;
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = ST_WAIT_ACK;
                end else begin
                    tx_en_s   = 1'b0;
                end
            end

            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    // uart_tx never took the byte: abandon the whole frame.
                    timeout_err_s = 1'b1;
                    busy_s        = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    // cnt_r stays at or below CNT_LAST, so it cannot wrap.
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_r == LAST_IDX) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end

            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_60mhz) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            snapshot_r    <= 24'h000000;
            idx_r         <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            tx_en_r       <= 1'b0;
            tx_data_r     <= 8'h00;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            snapshot_r    <= snapshot_s;
            idx_r         <= idx_s;
            cnt_r         <= cnt_s;
            tx_en_r       <= tx_en_s;
            tx_data_r     <= tx_data_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign tx_en       = tx_en_r;
    assign tx_data     = tx_data_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_hex_dump_tx.sv
// Self-checking bench for hex_dump_tx: two configurations, a uart_tx handshake
// model per instance, a procedural reference model and a per-cycle comparator.
module tb_hex_dump_tx;

    localparam int BT0 = 16;   // instance 0: upper case, CR LF
    localparam int BT1 = 32;   // instance 1: lower case, no CR LF

    logic        clk;
    logic        rst;
    logic        start_v   [2];
    logic [23:0] hex_v     [2];
    logic        tx_busy_v [2];
    logic        tx_en_v   [2];
    logic [7:0]  tx_data_v [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        err_v     [2];

    logic        exp_en    [2];
    logic [7:0]  exp_data  [2];
    logic        exp_busy  [2];
    logic        exp_done  [2];
    logic        exp_err   [2];

    int          en_cnt [2];
    int          en_cyc [2];
    int          done_cnt [2];
    int          err_cnt [2];
    int          err_cyc [2];
    bit          force_busy [2];
    bit          mute [2];
    bit          uart_rand;
    bit          chk_on;
    int          cyc;
    int          n_tests;
    int          n_fail;
    logic [7:0]  log0 [$];
    logic [7:0]  log1 [$];

    hex_dump_tx #(.BUSY_TIMEOUT(BT0), .LOWER_CASE(0), .SEND_CRLF(1)) dut0 (
        .clk_60mhz(clk), .rst(rst), .start(start_v[0]), .hex_in(hex_v[0]),
        .tx_busy(tx_busy_v[0]), .tx_en(tx_en_v[0]), .tx_data(tx_data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .timeout_err(err_v[0]));

    hex_dump_tx #(.BUSY_TIMEOUT(BT1), .LOWER_CASE(1), .SEND_CRLF(0)) dut1 (
        .clk_60mhz(clk), .rst(rst), .start(start_v[1]), .hex_in(hex_v[1]),
        .tx_busy(tx_busy_v[1]), .tx_en(tx_en_v[1]), .tx_data(tx_data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .timeout_err(err_v[1]));

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected ASCII code for character i of a frame built from value v.
    function automatic logic [7:0] exp_char(input bit lower, input logic [23:0] v, input int i);
        int d;
        if (i == 6) return 8'h0D;
        if (i == 7) return 8'h0A;
        d = int'((v >> (20 - 4 * i)) & 24'h00000F);
        if (d < 10) return 8'(48 + d);
        return 8'((lower ? 97 : 65) + d - 10);
    endfunction

    task automatic chk(input int k, input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input int k, input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", nm, k, cyc, act, exp);
        end
    endtask

    // Compare logged bytes with a literal frame packed MSB-first into 64 bits.
    task automatic chk_log(input int k, input string nm, input logic [63:0] e, input int n);
        int sz;
        logic [7:0] got;
        sz = (k == 0) ? log0.size() : log1.size();
        chk_int(k, nm, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            got = (k == 0) ? log0[i] : log1[i];
            chk(k, nm, got, e[63 - 8 * i -: 8]);
        end
    endtask

    // One clock edge of the reference model; reports whether reset was sampled.
    task automatic step(input int k, output bit aborted);
        @(posedge clk);
        exp_en[k]   = 1'b0;
        exp_done[k] = 1'b0;
        exp_err[k]  = 1'b0;
        aborted     = rst;
        if (rst) begin
            exp_busy[k] = 1'b0;
            exp_data[k] = 8'h00;
        end
    endtask

    // Reference model: a frame is a list of characters, each sent when the line
    // is free, acknowledged within the timeout, then released by uart_tx.
    task automatic model(input int k);
        bit          ab;
        int          n;
        int          last;
        int          bt;
        bit          lower;
        logic [23:0] snap;
        last  = (k == 0) ? 7 : 5;
        bt    = (k == 0) ? BT0 : BT1;
        lower = (k == 1);
        forever begin
            step(k, ab);
            if (!ab && start_v[k]) begin
                snap        = hex_v[k];
                exp_busy[k] = 1'b1;
                for (int i = 0; i <= last; i++) begin
                    forever begin
                        step(k, ab);
                        if (ab || !tx_busy_v[k]) break;
                    end
                    if (ab) break;
                    exp_en[k]   = 1'b1;
                    exp_data[k] = exp_char(lower, snap, i);
                    n = 0;
                    forever begin
                        step(k, ab);
                        if (ab || tx_busy_v[k]) break;
                        n++;
                        if (n == bt) break;
                    end
                    if (ab) break;
                    if (!tx_busy_v[k]) begin
                        exp_err[k]  = 1'b1;
                        exp_busy[k] = 1'b0;
                        break;
                    end
                    forever begin
                        step(k, ab);
                        if (ab || !tx_busy_v[k]) break;
                    end
                    if (ab) break;
                    if (i == last) begin
                        exp_done[k] = 1'b1;
                        exp_busy[k] = 1'b0;
                    end
                end
            end
        end
    endtask

    // uart_tx stand-in: busy for a number of cycles after each tx_en.
    task automatic uart(input int k);
        int rem;
        rem = 0;
        forever begin
            @(negedge clk);
            if (tx_en_v[k] === 1'b1 && !mute[k]) begin
                rem = uart_rand ? int'($urandom_range(12, 1)) : 10;
            end else if (rem > 0) begin
                rem--;
            end
            tx_busy_v[k] = force_busy[k] || (rem > 0);
        end
    endtask

    // Per-cycle comparison of every output of both instances.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_on) begin
                for (int k = 0; k < 2; k++) begin
                    chk(k, "tx_en", {7'd0, tx_en_v[k]}, {7'd0, exp_en[k]});
                    chk(k, "tx_data", tx_data_v[k], exp_data[k]);
                    chk(k, "busy", {7'd0, busy_v[k]}, {7'd0, exp_busy[k]});
                    chk(k, "done", {7'd0, done_v[k]}, {7'd0, exp_done[k]});
                    chk(k, "timeout_err", {7'd0, err_v[k]}, {7'd0, exp_err[k]});
                    if (tx_en_v[k] === 1'b1) begin
                        en_cnt[k]++;
                        en_cyc[k] = cyc;
                        if (k == 0) log0.push_back(tx_data_v[k]);
                        else        log1.push_back(tx_data_v[k]);
                    end
                    if (done_v[k] === 1'b1) done_cnt[k]++;
                    if (err_v[k] === 1'b1) begin
                        err_cnt[k]++;
                        err_cyc[k] = cyc;
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input int k, input logic [23:0] h);
        @(negedge clk);
        hex_v[k]   = h;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    // Wait for the next done or timeout_err of instance k, bounded.
    task automatic wait_end(input int k, input int budget);
        int base;
        int c;
        base = done_cnt[k] + err_cnt[k];
        c = 0;
        while (done_cnt[k] + err_cnt[k] == base && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt[k] + err_cnt[k] == base) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_end[%0d] cycle %0d: no frame end within %0d cycles", k, cyc, budget);
        end
    endtask

    // Wait until instance k has transmitted n bytes, bounded.
    task automatic wait_log(input int k, input int n, input int budget);
        int c;
        c = 0;
        while (((k == 0) ? log0.size() : log1.size()) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (((k == 0) ? log0.size() : log1.size()) < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_log[%0d] cycle %0d: fewer than %0d bytes within %0d cycles", k, cyc, n, budget);
        end
    endtask

    // Directed scenarios followed by randomized frames.
    initial begin
        int          k;
        int          base_done;
        int          base_err;
        logic [31:0] rv;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;  hex_v[i] = 24'h0;  tx_busy_v[i] = 1'b0;
            force_busy[i] = 1'b0;  mute[i] = 1'b0;
            exp_en[i] = 1'b0;  exp_data[i] = 8'h00;  exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;  exp_err[i] = 1'b0;
            en_cnt[i] = 0;  en_cyc[i] = 0;  done_cnt[i] = 0;  err_cnt[i] = 0;  err_cyc[i] = 0;
        end
        uart_rand = 1'b0;  chk_on = 1'b0;  cyc = 0;  n_tests = 0;  n_fail = 0;

        fork
            model(0);
            model(1);
            uart(0);
            uart(1);
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk(0, "rst_tx_en", {7'd0, tx_en_v[0]}, 8'h00);
        chk(0, "rst_busy", {7'd0, busy_v[0]}, 8'h00);
        chk(0, "rst_tx_data", tx_data_v[0], 8'h00);
        chk(1, "rst_done", {7'd0, done_v[1]}, 8'h00);
        chk(1, "rst_err", {7'd0, err_v[1]}, 8'h00);
        rst = 1'b0;

        // Full frame, with an ignored start and a changed hex_in mid-frame.
        log0.delete();
        base_done = done_cnt[0];
        pulse_start(0, 24'h12AB9F);
        wait_log(0, 3, 400);
        pulse_start(0, 24'h000000);
        wait_end(0, 600);
        chk_log(0, "frame_12AB9F", 64'h3132_4142_3946_0D0A, 8);
        chk_int(0, "frame_done_count", done_cnt[0] - base_done, 1);

        // Handshake timeout: uart never acknowledges.
        mute[0] = 1'b1;
        log0.delete();
        base_done = done_cnt[0];
        base_err  = err_cnt[0];
        pulse_start(0, 24'h5A5A5A);
        wait_end(0, 200);
        mute[0] = 1'b0;
        chk_int(0, "timeout_err_count", err_cnt[0] - base_err, 1);
        chk_int(0, "timeout_no_done", done_cnt[0] - base_done, 0);
        chk_int(0, "timeout_latency", err_cyc[0] - en_cyc[0], 16);
        chk_log(0, "timeout_frame", 64'h3500_0000_0000_0000, 1);
        chk(0, "timeout_busy_low", {7'd0, busy_v[0]}, 8'h00);
        log0.delete();
        pulse_start(0, 24'h000001);
        wait_end(0, 600);
        chk_log(0, "restart_frame", 64'h3030_3030_3031_0D0A, 8);

        // Reset while waiting for uart_tx to finish character 3.
        log0.delete();
        base_done = done_cnt[0];
        base_err  = err_cnt[0];
        pulse_start(0, 24'h12AB9F);
        wait_log(0, 4, 400);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(0, "midrst_tx_en", {7'd0, tx_en_v[0]}, 8'h00);
        chk(0, "midrst_busy", {7'd0, busy_v[0]}, 8'h00);
        chk(0, "midrst_done", {7'd0, done_v[0]}, 8'h00);
        chk_int(0, "midrst_no_done", done_cnt[0] - base_done, 0);
        chk_int(0, "midrst_no_err", err_cnt[0] - base_err, 0);
        log0.delete();
        pulse_start(0, 24'h12AB9F);
        wait_end(0, 600);
        chk_log(0, "after_rst_frame", 64'h3132_4142_3946_0D0A, 8);

        // Line held busy for 20 cycles at start.
        log0.delete();
        force_busy[0] = 1'b1;
        @(negedge clk);
        pulse_start(0, 24'h0BEEF0);
        repeat (18) @(negedge clk);
        chk_int(0, "held_no_tx_en", log0.size(), 0);
        force_busy[0] = 1'b0;
        wait_end(0, 600);
        chk_log(0, "held_frame", 64'h3042_4545_4630_0D0A, 8);

        // Lower case, no CR LF.
        log1.delete();
        base_done = done_cnt[1];
        pulse_start(1, 24'hFFFFFF);
        wait_end(1, 600);
        chk_log(1, "lower_FFFFFF", 64'h6666_6666_6666_0000, 6);
        chk_int(1, "lower_done_count", done_cnt[1] - base_done, 1);

        // Randomized frames, stray starts and back-to-back requests.
        uart_rand = 1'b1;
        for (int r = 0; r < 16; r++) begin
            k  = r % 2;
            rv = $urandom;
            pulse_start(k, rv[23:0]);
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(20, 5)) @(negedge clk);
                rv = $urandom;
                pulse_start(k, rv[23:0]);
            end
            wait_end(k, 800);
            if (r % 4 == 3) begin
                rv = $urandom;
                hex_v[k]   = rv[23:0];
                start_v[k] = 1'b1;
                @(negedge clk);
                start_v[k] = 1'b0;
                wait_end(k, 800);
            end
        end

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
